// File: rtl/sparse_polymult_pkg.sv
// Shared types and parameter helpers for the sparse-by-dense GF(2) multiplier controller.
package sparse_polymult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SP_REQ,
    ST_SETUP,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Sparse slots packed per sparse RAM word.
  function automatic int unsigned calc_ppw(input int unsigned word_width,
                                           input int unsigned pos_width);
    return word_width / pos_width;
  endfunction

  // Bit-shift width: log2 of the word width.
  function automatic int unsigned calc_shw(input int unsigned word_width);
    return $clog2(word_width);
  endfunction

  // Index of the dummy flag inside a sparse slot.
  function automatic int unsigned dummy_bit(input int unsigned pos_width);
    return pos_width - 1;
  endfunction

endpackage

// File: rtl/sparse_polymult_ctrl_word_shift_merge.sv
// Combinational merge of one shifted dense word into an accumulator word.
// cur/prev: dense words j and j-1; s: bit shift; dummy: pass acc_rdata through.
module word_shift_merge #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned SHW        = 5
) (
  input  logic [WORD_WIDTH-1:0] cur,
  input  logic [WORD_WIDTH-1:0] prev,
  input  logic [SHW-1:0]        s,
  input  logic                  dummy,
  input  logic [WORD_WIDTH-1:0] acc_rdata,
  output logic [WORD_WIDTH-1:0] acc_wdata
);

  logic [SHW:0]          rsh;
  logic [WORD_WIDTH-1:0] carry;
  logic [WORD_WIDTH-1:0] shifted;

  always_comb begin
    rsh       = (SHW+1)'(WORD_WIDTH) - {1'b0, s};
    // A full-width right shift would be out of range, so s = 0 carries nothing.
    carry     = (s == '0) ? '0 : (prev >> rsh);
    shifted   = (cur << s) | carry;
    acc_wdata = dummy ? acc_rdata : (acc_rdata ^ shifted);
  end

endmodule

// File: rtl/sparse_polymult_ctrl.sv
// Sparse-by-dense GF(2) polynomial multiply controller.
// Ports: clk/rst, start/busy/done handshake, sparse and dense RAM read ports,
// accumulator read port and write port (acc_waddr/acc_wdata/acc_we).
module sparse_polymult_ctrl
  import sparse_polymult_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned N_WORDS    = 553,
  parameter int unsigned WEIGHT     = 66,
  parameter int unsigned POS_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] sparse_addr,
  input  logic [WORD_WIDTH-1:0] sparse_data,
  output logic [ADDR_WIDTH-1:0] dense_addr,
  input  logic [WORD_WIDTH-1:0] dense_data,
  output logic [ADDR_WIDTH-1:0] acc_raddr,
  input  logic [WORD_WIDTH-1:0] acc_rdata,
  output logic [ADDR_WIDTH-1:0] acc_waddr,
  output logic [WORD_WIDTH-1:0] acc_wdata,
  output logic                  acc_we
);

  localparam int unsigned PPW   = calc_ppw(WORD_WIDTH, POS_WIDTH);
  localparam int unsigned SHW   = calc_shw(WORD_WIDTH);
  localparam int unsigned DFLAG = dummy_bit(POS_WIDTH);
  localparam int unsigned KW    = (WEIGHT > 1) ? $clog2(WEIGHT) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_J = ADDR_WIDTH'(N_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_D = ADDR_WIDTH'(N_WORDS - 1);
  localparam logic [KW-1:0]         LAST_K = KW'(WEIGHT - 1);

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [ADDR_WIDTH-1:0] j_q, j_d;
  logic [ADDR_WIDTH-1:0] q_q, q_d;
  logic [SHW-1:0]        s_q, s_d;
  logic                  dummy_q, dummy_d;
  logic [WORD_WIDTH-1:0] prev_q, prev_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [31:0]           fld;
  logic [POS_WIDTH-1:0]  slot;
  logic [POS_WIDTH-2:0]  pos;
  logic [WORD_WIDTH-1:0] cur_word;
  logic [WORD_WIDTH-1:0] merged;
  logic                  we;

  word_shift_merge #(
    .WORD_WIDTH (WORD_WIDTH),
    .SHW        (SHW)
  ) u_merge (
    .cur       (cur_word),
    .prev      (prev_q),
    .s         (s_q),
    .dummy     (dummy_q),
    .acc_rdata (acc_rdata),
    .acc_wdata (merged)
  );

  // Datapath and address generation. The write index trails the read index
  // by one; j_q runs to N_WORDS+1 so DRAIN reuses the same q+j-1 address.
  always_comb begin
    fld      = 32'(k_q) % PPW;
    slot     = POS_WIDTH'(sparse_data >> (fld * POS_WIDTH));
    pos      = slot[POS_WIDTH-2:0];
    // Data returned in DRAIN belongs to the masked j = N_WORDS request.
    cur_word = (state_q == ST_DRAIN) ? '0 : dense_data;
    we       = ((state_q == ST_STREAM) && (j_q != '0)) || (state_q == ST_DRAIN);

    sparse_addr = (state_q == ST_SP_REQ) ? ADDR_WIDTH'(32'(k_q) / PPW) : '0;
    dense_addr  = '0;
    acc_raddr   = '0;
    if (state_q == ST_STREAM) begin
      dense_addr = (j_q > LAST_D) ? LAST_D : j_q;
      acc_raddr  = q_q + j_q;
    end
    acc_we    = we;
    acc_waddr = we ? (q_q + j_q - ADDR_WIDTH'(1)) : '0;
    acc_wdata = we ? merged : '0;
    busy      = busy_q;
    done      = done_q;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    q_d     = q_q;
    s_d     = s_q;
    dummy_d = dummy_q;
    prev_d  = prev_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SP_REQ;
          k_d     = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SP_REQ: state_d = ST_SETUP;
      ST_SETUP: begin
        q_d     = ADDR_WIDTH'(pos >> SHW);
        s_d     = pos[SHW-1:0];
        dummy_d = slot[DFLAG];
        prev_d  = '0;
        j_d     = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        j_d = j_q + ADDR_WIDTH'(1);
        if (we) begin
          prev_d = cur_word;
        end
        if (j_q == LAST_J) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (k_q == LAST_K) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = ST_SP_REQ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      j_q     <= '0;
      q_q     <= '0;
      s_q     <= '0;
      dummy_q <= 1'b0;
      prev_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      q_q     <= q_d;
      s_q     <= s_d;
      dummy_q <= dummy_d;
      prev_q  <= prev_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_sparse_polymult_ctrl.sv
module tb_sparse_polymult_ctrl;

  localparam int WW = 32;
  localparam int NW = 4;
  localparam int WT = 2;
  localparam int PW = 16;
  localparam int AW = 4;
  localparam int RUN_CYCLES = 1 + WT * (NW + 4);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] sparse_addr;
  logic [WW-1:0] sparse_data;
  logic [AW-1:0] dense_addr;
  logic [WW-1:0] dense_data;
  logic [AW-1:0] acc_raddr;
  logic [WW-1:0] acc_rdata;
  logic [AW-1:0] acc_waddr;
  logic [WW-1:0] acc_wdata;
  logic          acc_we;

  logic [WW-1:0] dense_mem  [0:15];
  logic [WW-1:0] sparse_mem [0:15];
  logic [WW-1:0] acc_mem    [0:15];
  logic [WW-1:0] acc_init   [0:15];
  logic [WW-1:0] model_acc  [0:15];
  logic          acc_load;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  sparse_polymult_ctrl #(
    .WORD_WIDTH (WW),
    .N_WORDS    (NW),
    .WEIGHT     (WT),
    .POS_WIDTH  (PW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .sparse_addr (sparse_addr),
    .sparse_data (sparse_data),
    .dense_addr  (dense_addr),
    .dense_data  (dense_data),
    .acc_raddr   (acc_raddr),
    .acc_rdata   (acc_rdata),
    .acc_waddr   (acc_waddr),
    .acc_wdata   (acc_wdata),
    .acc_we      (acc_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dense_data  <= dense_mem[dense_addr];
    sparse_data <= sparse_mem[sparse_addr];
    acc_rdata   <= acc_mem[acc_raddr];
    if (acc_load) acc_mem <= acc_init;
    else if (acc_we) acc_mem[acc_waddr] <= acc_wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: acc[q+j] ^= upper half of ({d[j], d[j-1]} << s).
  task automatic push_slot(input logic [PW-1:0] slot);
    int unsigned p;
    int unsigned q;
    int unsigned s;
    p = 32'(slot[PW-2:0]);
    q = p / WW;
    s = p % WW;
    for (int j = 0; j <= NW; j++) begin
      logic [WW-1:0]   dj;
      logic [WW-1:0]   djm;
      logic [2*WW-1:0] wide;
      wr_t             e;
      dj     = (j < NW) ? dense_mem[j] : '0;
      djm    = (j > 0) ? dense_mem[j-1] : '0;
      wide   = {dj, djm} << s;
      e.addr = AW'(q + 32'(j));
      e.data = slot[PW-1] ? model_acc[q+32'(j)] : (model_acc[q+32'(j)] ^ wide[2*WW-1:WW]);
      model_acc[q+32'(j)] = e.data;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_run(input logic [PW-1:0] s0, input logic [PW-1:0] s1,
                        input bit load, input bit pulse_busy, input bit abort);
    int  done_n  = 0;
    int  writes  = 0;
    int  run_len = 0;
    bit  aborted = 0;
    wr_t e;
    @(negedge clk);
    sparse_mem[0] = {s1, s0};
    if (load) begin
      acc_load = 1'b1;
      for (int i = 0; i < 16; i++) model_acc[i] = acc_init[i];
    end
    exp_q.delete();
    push_slot(s0);
    push_slot(s1);
    start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start    = 1'b0;
        acc_load = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        check("done_low_at_start", 64'(done), 64'(0));
      end
      if (pulse_busy) start = (c == 5);
      if (abort && c == 7) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_we", 64'(acc_we), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_waddr", 64'(acc_waddr), 64'(0));
        aborted = 1;
        break;
      end
      if (acc_we) begin
        writes++;
        run_len++;
        check("wr_queue_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("acc_waddr", 64'(acc_waddr), 64'(e.addr));
          check("acc_wdata", 64'(acc_wdata), 64'(e.data));
        end
      end else if (run_len != 0) begin
        check("we_burst_len", 64'(run_len), 64'(NW + 1));
        run_len = 0;
      end
      if (done) begin
        done_n = c;
        check("busy_low_with_done", 64'(busy), 64'(0));
        break;
      end
    end
    if (!aborted) begin
      check("done_cycle", 64'(done_n), 64'(RUN_CYCLES));
      check("write_count", 64'(writes), 64'(WT * (NW + 1)));
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      for (int i = 0; i < 16; i++) check("acc_final", 64'(acc_mem[i]), 64'(model_acc[i]));
    end
  endtask

  task automatic set_acc_init(input bit rand_fill);
    for (int i = 0; i < 16; i++) acc_init[i] = rand_fill ? $urandom : '0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    acc_load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dense_mem[i]  = '0;
      sparse_mem[i] = '0;
      acc_mem[i]    = '0;
      acc_init[i]   = '0;
      model_acc[i]  = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_we", 64'(acc_we), 64'(0));
    check("rst_waddr", 64'(acc_waddr), 64'(0));
    check("rst_wdata", 64'(acc_wdata), 64'(0));
    check("rst_raddr", 64'(acc_raddr), 64'(0));
    check("rst_daddr", 64'(dense_addr), 64'(0));
    check("rst_saddr", 64'(sparse_addr), 64'(0));
    rst = 1'b0;

    // p=0 real plus dummy p=0: plain copy of the dense operand.
    dense_mem[0] = 32'h1; dense_mem[1] = 32'h2; dense_mem[2] = 32'h3; dense_mem[3] = 32'h4;
    set_acc_init(0);
    do_run(16'h0000, 16'h8000, 1, 0, 0);
    check("a_acc0", 64'(acc_mem[0]), 64'h1);
    check("a_acc1", 64'(acc_mem[1]), 64'h2);
    check("a_acc2", 64'(acc_mem[2]), 64'h3);
    check("a_acc3", 64'(acc_mem[3]), 64'h4);
    check("a_acc4", 64'(acc_mem[4]), 64'h0);

    // p=33 carries the top bit of word 0 into word 2.
    dense_mem[0] = 32'h8000_0001; dense_mem[1] = '0; dense_mem[2] = '0; dense_mem[3] = '0;
    do_run(16'd33, 16'h8000, 1, 0, 0);
    check("b_acc1", 64'(acc_mem[1]), 64'h2);
    check("b_acc2", 64'(acc_mem[2]), 64'h1);
    check("b_acc3", 64'(acc_mem[3]), 64'h0);

    // Two identical slots cancel; a start mid-run must be ignored.
    for (int i = 0; i < NW; i++) dense_mem[i] = $urandom;
    do_run(16'd5, 16'd5, 1, 1, 0);
    for (int i = 0; i < 16; i++) check("c_cancel", 64'(acc_mem[i]), 64'(0));

    // Dummy slots leave a non-zero accumulator untouched.
    set_acc_init(1);
    do_run(16'h8000 | 16'd40, 16'h8000 | 16'd40, 1, 0, 0);
    for (int i = 0; i < 16; i++) check("d_unchanged", 64'(acc_mem[i]), 64'(acc_init[i]));

    // Abort mid-stream, then a full rerun from the same initial contents.
    do_run(16'd100, 16'd7, 1, 0, 1);
    do_run(16'd100, 16'd7, 1, 0, 0);

    // Back-to-back run accumulating on top of the previous result.
    do_run(16'h8000 | 16'd3, 16'd64, 0, 0, 0);

    @(negedge clk);
    check("idle_done", 64'(done), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
